// File: rtl/seg7_pkg.sv
// seg7_pkg: glyph constants, controller states and BCD sizing shared by the seg7 display slice
package seg7_pkg;
  localparam logic [6:0] GLYPH_0     = 7'b1000000;
  localparam logic [6:0] GLYPH_1     = 7'b1111001;
  localparam logic [6:0] GLYPH_2     = 7'b0100100;
  localparam logic [6:0] GLYPH_3     = 7'b0110000;
  localparam logic [6:0] GLYPH_4     = 7'b0011001;
  localparam logic [6:0] GLYPH_5     = 7'b0010010;
  localparam logic [6:0] GLYPH_6     = 7'b0000010;
  localparam logic [6:0] GLYPH_7     = 7'b1111000;
  localparam logic [6:0] GLYPH_8     = 7'b0000000;
  localparam logic [6:0] GLYPH_9     = 7'b0010000;
  localparam logic [6:0] GLYPH_A     = 7'b0001000;
  localparam logic [6:0] GLYPH_B     = 7'b0000011;
  localparam logic [6:0] GLYPH_C     = 7'b1000110;
  localparam logic [6:0] GLYPH_D     = 7'b0100001;
  localparam logic [6:0] GLYPH_E     = 7'b0000110;
  localparam logic [6:0] GLYPH_F     = 7'b0001110;
  localparam logic [6:0] GLYPH_DASH  = 7'b0111111;
  localparam logic [6:0] GLYPH_BLANK = 7'b1111111;
  typedef enum logic [1:0] {IDLE, CONV, UPDATE} state_t;
  // decimal digits needed to show the largest data_w-bit value
  function automatic int bcd_digits(input int data_w);
    logic [63:0] v;
    int n;
    v = (64'd1 << data_w) - 64'd1;
    n = 1;
    while (v >= 64'd10) begin
      v = v / 64'd10;
      n++;
    end
    return n;
  endfunction
endpackage

// File: rtl/seg7_glyph.sv
// seg7_glyph: one nibble to an active-low {g..a} segment pattern, dash taking priority over blank
module seg7_glyph
  import seg7_pkg::*;
(
  input  logic [3:0] nib,
  input  logic       blank,
  input  logic       dash,
  output logic [6:0] seg
);
  logic [6:0] lut;
  always_comb begin
    lut = GLYPH_BLANK;
    case (nib)
      4'h0: lut = GLYPH_0;
      4'h1: lut = GLYPH_1;
      4'h2: lut = GLYPH_2;
      4'h3: lut = GLYPH_3;
      4'h4: lut = GLYPH_4;
      4'h5: lut = GLYPH_5;
      4'h6: lut = GLYPH_6;
      4'h7: lut = GLYPH_7;
      4'h8: lut = GLYPH_8;
      4'h9: lut = GLYPH_9;
      4'hA: lut = GLYPH_A;
      4'hB: lut = GLYPH_B;
      4'hC: lut = GLYPH_C;
      4'hD: lut = GLYPH_D;
      4'hE: lut = GLYPH_E;
      4'hF: lut = GLYPH_F;
      default: lut = GLYPH_BLANK;
    endcase
    seg = dash ? GLYPH_DASH : blank ? GLYPH_BLANK : lut;
  end
endmodule

// File: rtl/seg7_bin_display.sv
// seg7_bin_display: binary value to DIGITS registered 7-segment glyphs, hex nibbles or
// sequential double-dabble decimal, with leading-zero blanking and overflow dashes
module seg7_bin_display
  import seg7_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int DIGITS     = 5,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [DATA_W-1:0]     data,
  input  logic                  hex_mode,
  input  logic                  blank_lz,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [7*DIGITS-1:0]   segs
);
  localparam int BW = 4 * DIGITS;
  localparam int HW = DATA_W > BW ? DATA_W : BW;
  localparam int CW = $clog2(DATA_W);
  localparam bit CAN_OVF = bcd_digits(DATA_W) > DIGITS;
  localparam logic [7*DIGITS-1:0] SEG_RST = {(7*DIGITS){ACTIVE_LOW}};
  state_t state_q, state_d;
  logic busy_q, busy_d, done_q, done_d, ovf_disp_q, ovf_disp_d;
  logic ovf_q, ovf_d, hex_q, hex_d, blz_q, blz_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic [BW-1:0] bcd_q, bcd_d, bcd_adj;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7*DIGITS-1:0] segs_q, segs_d, glyphs;
  logic [HW-1:0] hex_ext;
  logic [3:0] nib [DIGITS];
  logic [DIGITS-1:0] blk;
  logic dash, hex_ovf;
  assign hex_ext = HW'(sh_q);
  assign hex_ovf = |(sh_q >> BW);
  assign dash = hex_q ? hex_ovf : ovf_q;
  // scan from the top digit so blanking stops at the first nonzero digit
  always_comb begin : display
    logic zr;
    zr = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      nib[i] = hex_q ? hex_ext[4*i+:4] : bcd_q[4*i+:4];
      zr = zr && (nib[i] == 4'd0);
      blk[i] = (blz_q && zr && i != 0) || (!hex_q && nib[i] > 4'd9);
    end
  end
  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    seg7_glyph u_glyph (
      .nib   (nib[g]),
      .blank (blk[g]),
      .dash  (dash),
      .seg   (glyphs[7*g+:7])
    );
  end
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < DIGITS; i++)
      bcd_adj[4*i+:4] = bcd_q[4*i+:4] >= 4'd5 ? bcd_q[4*i+:4] + 4'd3 : bcd_q[4*i+:4];
  end
  always_comb begin
    state_d = state_q;
    busy_d = busy_q;
    done_d = 1'b0;
    ovf_disp_d = ovf_disp_q;
    ovf_d = ovf_q;
    hex_d = hex_q;
    blz_d = blz_q;
    sh_d = sh_q;
    bcd_d = bcd_q;
    cnt_d = cnt_q;
    segs_d = segs_q;
    case (state_q)
      IDLE: begin
        // busy_q still high here means this is the done cycle: retire, ignore load
        if (busy_q) begin
          busy_d = 1'b0;
        end else if (load) begin
          busy_d = 1'b1;
          sh_d = data;
          hex_d = hex_mode;
          blz_d = blank_lz;
          bcd_d = '0;
          ovf_d = 1'b0;
          cnt_d = '0;
          state_d = hex_mode ? UPDATE : CONV;
        end
      end
      CONV: begin
        bcd_d = {bcd_adj[BW-2:0], sh_q[DATA_W-1]};
        sh_d = sh_q << 1;
        ovf_d = ovf_q | (CAN_OVF & bcd_adj[BW-1]);
        cnt_d = cnt_q + 1'b1;
        state_d = cnt_q == CW'(DATA_W - 1) ? UPDATE : CONV;
      end
      UPDATE: begin
        segs_d = ACTIVE_LOW ? glyphs : ~glyphs;
        ovf_disp_d = dash;
        done_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      ovf_disp_q <= 1'b0;
      ovf_q <= 1'b0;
      hex_q <= 1'b0;
      blz_q <= 1'b0;
      sh_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
      segs_q <= SEG_RST;
    end else begin
      state_q <= state_d;
      busy_q <= busy_d;
      done_q <= done_d;
      ovf_disp_q <= ovf_disp_d;
      ovf_q <= ovf_d;
      hex_q <= hex_d;
      blz_q <= blz_d;
      sh_q <= sh_d;
      bcd_q <= bcd_d;
      cnt_q <= cnt_d;
      segs_q <= segs_d;
    end
  end
  assign busy = busy_q;
  assign done = done_q;
  assign overflow = ovf_disp_q;
  assign segs = segs_q;
endmodule

// File: tb/tb_seg7_bin_display.sv
// tb_seg7_bin_display: scoreboard bench for two display instances (5 digits active-low,
// 4 digits active-high) against an arithmetic model of the expected glyph image
module tb_seg7_bin_display;
  typedef struct {
    logic [34:0] segs;
    logic        ovf;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic ld5 = 1'b0;
  logic ld4 = 1'b0;
  logic hex_mode = 1'b0;
  logic blank_lz = 1'b0;
  logic [15:0] data = '0;
  logic busy5, done5, ovf5, busy4, done4, ovf4;
  logic [34:0] segs5;
  logic [27:0] segs4;
  int total = 0;
  int bad = 0;
  exp_t q5[$];
  exp_t q4[$];
  exp_t e5, e4;
  logic [6:0] gl [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                          7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                          7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                          7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
  always #5 clk = ~clk;
  seg7_bin_display #(.DATA_W(16), .DIGITS(5), .ACTIVE_LOW(1'b1)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .load(ld5), .data(data), .hex_mode(hex_mode),
    .blank_lz(blank_lz), .busy(busy5), .done(done5), .overflow(ovf5), .segs(segs5)
  );
  seg7_bin_display #(.DATA_W(16), .DIGITS(4), .ACTIVE_LOW(1'b0)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .load(ld4), .data(data), .hex_mode(hex_mode),
    .blank_lz(blank_lz), .busy(busy4), .done(done4), .overflow(ovf4), .segs(segs4)
  );
  function automatic exp_t model(input int v, input bit hex, input bit blz, input int nd, input bit al);
    exp_t r;
    int dig [8];
    int p, msd;
    bit ov;
    logic [6:0] g;
    r.segs = '0;
    p = 1;
    for (int i = 0; i < nd; i++) begin
      dig[i] = hex ? (v >> (4 * i)) & 15 : (v / p) % 10;
      p = p * 10;
    end
    ov = hex ? ((v >> (4 * nd)) != 0) : (v >= p);
    msd = 0;
    for (int i = 0; i < nd; i++) if (dig[i] != 0) msd = i;
    for (int i = 0; i < nd; i++) begin
      g = ov ? 7'b0111111 : (blz && i > msd) ? 7'b1111111 : gl[dig[i]];
      r.segs[7*i+:7] = al ? g : ~g;
    end
    r.ovf = ov;
    return r;
  endfunction
  always @(negedge clk) begin
    if (done5) begin
      total++;
      if (q5.size() == 0) begin
        bad++;
        $display("FAIL sb5_unexpected_done segs=%h ovf=%b want no done", segs5, ovf5);
      end else begin
        e5 = q5.pop_front();
        if (segs5 !== e5.segs || ovf5 !== e5.ovf) begin
          bad++;
          $display("FAIL sb5 segs=%h ovf=%b want segs=%h ovf=%b", segs5, ovf5, e5.segs, e5.ovf);
        end
      end
    end
  end
  always @(negedge clk) begin
    if (done4) begin
      total++;
      if (q4.size() == 0) begin
        bad++;
        $display("FAIL sb4_unexpected_done segs=%h ovf=%b want no done", segs4, ovf4);
      end else begin
        e4 = q4.pop_front();
        if ({7'b0, segs4} !== e4.segs || ovf4 !== e4.ovf) begin
          bad++;
          $display("FAIL sb4 segs=%h ovf=%b want segs=%h ovf=%b", segs4, ovf4, e4.segs, e4.ovf);
        end
      end
    end
  end
  task automatic run(input bit w4, input int v, input bit hex, input bit blz, input string name);
    int lat;
    @(negedge clk);
    data = v[15:0];
    hex_mode = hex;
    blank_lz = blz;
    if (w4) begin
      ld4 = 1'b1;
      q4.push_back(model(v, hex, blz, 4, 1'b0));
    end else begin
      ld5 = 1'b1;
      q5.push_back(model(v, hex, blz, 5, 1'b1));
    end
    @(posedge clk);
    #1;
    ld4 = 1'b0;
    ld5 = 1'b0;
    total++;
    if ((w4 ? busy4 : busy5) !== 1'b1) begin
      bad++;
      $display("FAIL %s_busy got=%b want=1", name, w4 ? busy4 : busy5);
    end
    lat = 0;
    while ((w4 ? done4 : done5) !== 1'b1 && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    total++;
    if (lat != (hex ? 1 : 17)) begin
      bad++;
      $display("FAIL %s_latency got=%0d want=%0d", name, lat, hex ? 1 : 17);
    end
    @(posedge clk);
    #1;
    total++;
    if ((w4 ? busy4 : busy5) !== 1'b0 || (w4 ? done4 : done5) !== 1'b0) begin
      bad++;
      $display("FAIL %s_retire busy=%b done=%b want 0 0", name, w4 ? busy4 : busy5, w4 ? done4 : done5);
    end
  endtask
  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({busy5, done5, ovf5, busy4, done4, ovf4} !== 6'b0) begin
      bad++;
      $display("FAIL reset_flags got=%b want=000000", {busy5, done5, ovf5, busy4, done4, ovf4});
    end
    total++;
    if (segs5 !== {35{1'b1}}) begin
      bad++;
      $display("FAIL reset_segs5 got=%h want=%h", segs5, {35{1'b1}});
    end
    total++;
    if (segs4 !== 28'h0) begin
      bad++;
      $display("FAIL reset_segs4 got=%h want=0", segs4);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic test_decimal();
    run(1'b0, 12345, 1'b0, 1'b0, "dec12345");
    total++;
    if (segs5 !== {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, 7'b0010010}) begin
      bad++;
      $display("FAIL dec12345_digits got=%h", segs5);
    end
    run(1'b0, 65535, 1'b0, 1'b1, "dec65535");
    run(1'b0, 7, 1'b0, 1'b1, "dec7");
    run(1'b0, 1009, 1'b0, 1'b1, "dec1009");
  endtask
  task automatic test_hex();
    run(1'b0, 16'h00AF, 1'b1, 1'b1, "hex00af");
    total++;
    if (segs5[6:0] !== 7'b0001110 || segs5[13:7] !== 7'b0001000 || segs5[34:14] !== {21{1'b1}}) begin
      bad++;
      $display("FAIL hex00af_digits got=%h", segs5);
    end
    run(1'b0, 16'hBEEF, 1'b1, 1'b0, "hexbeef");
    run(1'b1, 16'h1234, 1'b1, 1'b1, "hex4_1234");
    run(1'b1, 16'h00C0, 1'b1, 1'b1, "hex4_00c0");
  endtask
  task automatic test_zero();
    run(1'b0, 0, 1'b0, 1'b1, "zero_blz");
    total++;
    if (segs5 !== {{4{7'b1111111}}, 7'b1000000}) begin
      bad++;
      $display("FAIL zero_blz_digits got=%h", segs5);
    end
    run(1'b0, 0, 1'b0, 1'b0, "zero_full");
    total++;
    if (segs5 !== {5{7'b1000000}}) begin
      bad++;
      $display("FAIL zero_full_digits got=%h", segs5);
    end
    run(1'b1, 0, 1'b0, 1'b1, "zero4_blz");
  endtask
  task automatic test_overflow();
    run(1'b1, 10000, 1'b0, 1'b1, "ovf10000");
    total++;
    if (ovf4 !== 1'b1 || segs4 !== {4{7'b1000000}}) begin
      bad++;
      $display("FAIL ovf10000_dash ovf=%b segs=%h want 1 %h", ovf4, segs4, {4{7'b1000000}});
    end
    run(1'b1, 9999, 1'b0, 1'b0, "ovf9999");
    run(1'b1, 65535, 1'b0, 1'b0, "ovf65535");
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (ovf4 !== 1'b1) begin
      bad++;
      $display("FAIL ovf_hold got=%b want=1", ovf4);
    end
  endtask
  task automatic test_back_to_back();
    int dones, first;
    logic [34:0] prev;
    dones = 0;
    first = 0;
    prev = segs5;
    @(negedge clk);
    data = 16'd500;
    hex_mode = 1'b0;
    blank_lz = 1'b0;
    ld5 = 1'b1;
    q5.push_back(model(500, 1'b0, 1'b0, 5, 1'b1));
    @(posedge clk);
    #1;
    ld5 = 1'b0;
    for (int n = 1; n <= 30; n++) begin
      @(posedge clk);
      #1;
      if (n == 2) begin
        data = 16'd777;
        ld5 = 1'b1;
      end
      if (n == 3) ld5 = 1'b0;
      if (n == 5) begin
        total++;
        if (segs5 !== prev) begin
          bad++;
          $display("FAIL b2b_hold got=%h want=%h", segs5, prev);
        end
      end
      if (first != 0 && n == first + 1) begin
        ld5 = 1'b0;
        total++;
        if (busy5 !== 1'b0) begin
          bad++;
          $display("FAIL b2b_busy_low got=%b want=0", busy5);
        end
      end
      if (done5 === 1'b1) begin
        dones++;
        if (first == 0) begin
          first = n;
          data = 16'd777;
          ld5 = 1'b1;
        end
      end
    end
    ld5 = 1'b0;
    total++;
    if (dones != 1 || first != 17) begin
      bad++;
      $display("FAIL b2b_done dones=%0d at=%0d want 1 at 17", dones, first);
    end
  endtask
  task automatic test_reset_abort();
    int dones;
    @(negedge clk);
    data = 16'd12345;
    hex_mode = 1'b0;
    blank_lz = 1'b0;
    ld5 = 1'b1;
    @(posedge clk);
    #1;
    ld5 = 1'b0;
    repeat (8) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({busy5, done5, ovf5, busy4, done4, ovf4} !== 6'b0) begin
      bad++;
      $display("FAIL abort_flags got=%b want=000000", {busy5, done5, ovf5, busy4, done4, ovf4});
    end
    total++;
    if (segs5 !== {35{1'b1}} || segs4 !== 28'h0) begin
      bad++;
      $display("FAIL abort_segs got=%h %h want all blank", segs5, segs4);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    repeat (25) begin
      @(posedge clk);
      #1;
      if (done5 === 1'b1) dones++;
    end
    total++;
    if (dones != 0) begin
      bad++;
      $display("FAIL abort_no_done got=%0d want=0", dones);
    end
    run(1'b0, 4321, 1'b0, 1'b1, "post_abort");
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
  initial begin
    test_reset();
    test_decimal();
    test_hex();
    test_zero();
    test_overflow();
    test_back_to_back();
    test_reset_abort();
    repeat (3) @(posedge clk);
    total++;
    if (q5.size() != 0 || q4.size() != 0) begin
      bad++;
      $display("FAIL sb_drain left5=%0d left4=%0d want 0 0", q5.size(), q4.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
